// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU op/control codes and datapath mux selects. Honours MC_BNE_EN.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
`ifdef MC_BNE_EN
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12
`else
        S_JUMP    = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/aludec.sv
// ALU decoder shared by the single- and multicycle controllers: maps aluop and
// funct to the 3-bit ALU control code.
module aludec
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Unknown aluop/funct combinations fall back to add.
    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUC_ADD;
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALUC_ADD;
                    FUNCT_SUB: alucontrol = ALUC_SUB;
                    FUNCT_AND: alucontrol = ALUC_AND;
                    FUNCT_OR:  alucontrol = ALUC_OR;
                    FUNCT_SLT: alucontrol = ALUC_SLT;
                    default:   alucontrol = ALUC_ADD;
                endcase
            end
            default: alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS core with retired-instruction counter.
// Optional bne support is enabled by defining MC_BNE_EN.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pcen,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regwrite,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic        iord,
    output logic        memtoreg,
    output logic        regdst,
    output logic [2:0]  alucontrol,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] instret_r;
    logic [1:0]  aluop_s;
    logic        pcwrite_s;
    logic        branch_s;
    logic        branchne_s;
    logic        irwrite_s;
    logic        regwrite_s;
    logic        memwrite_s;
    logic        retire_s;
    logic        branch_taken_s;

    aludec u_aludec (
        .aluop      (aluop_s),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // State register and retired-instruction counter; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_FETCH;
            instret_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if (retire_s) begin
                instret_r <= instret_r + 32'd1;
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_next_s = S_FETCH;
        aluop_s      = ALUOP_ADD;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        branchne_s   = 1'b0;
        irwrite_s    = 1'b0;
        regwrite_s   = 1'b0;
        memwrite_s   = 1'b0;
        retire_s     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = ALUSRCB_B;
        pcsrc        = PCSRC_ALU;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        case (state_r)
            S_FETCH: begin
                irwrite_s    = 1'b1;
                pcwrite_s    = 1'b1;
                alusrcb      = ALUSRCB_FOUR;
                state_next_s = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = ALUSRCB_IMMSH;
                case (op)
                    OP_LW:    state_next_s = S_MEMADR;
                    OP_SW:    state_next_s = S_MEMADR;
                    OP_RTYPE: state_next_s = S_EXECUTE;
                    OP_BEQ:   state_next_s = S_BEQ;
                    OP_ADDI:  state_next_s = S_ADDIEX;
                    OP_J:     state_next_s = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:   state_next_s = S_BNE;
`endif
                    default:  state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
                if (op == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                iord         = 1'b1;
                state_next_s = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            S_EXECUTE: begin
                alusrca      = 1'b1;
                aluop_s      = ALUOP_FUNCT;
                state_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            S_BEQ: begin
                alusrca  = 1'b1;
                aluop_s  = ALUOP_SUB;
                pcsrc    = PCSRC_ALUOUT;
                branch_s = 1'b1;
                retire_s = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNE: begin
                alusrca    = 1'b1;
                aluop_s    = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branchne_s = 1'b1;
                retire_s   = 1'b1;
            end
`endif
            S_ADDIEX: begin
                alusrca      = 1'b1;
                alusrcb      = ALUSRCB_IMM;
                state_next_s = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = PCSRC_JUMP;
                pcwrite_s = 1'b1;
                retire_s  = 1'b1;
            end
            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

`ifdef MC_BNE_EN
    assign branch_taken_s = (branch_s & zero) | (branchne_s & ~zero);
`else
    assign branch_taken_s = (branch_s & zero) | (branchne_s & 1'b0);
`endif

    // Write enables are held low while reset is asserted so a partial instruction commits nothing.
    assign pcen     = (pcwrite_s | branch_taken_s) & ~reset;
    assign irwrite  = irwrite_s & ~reset;
    assign regwrite = regwrite_s & ~reset;
    assign memwrite = memwrite_s & ~reset;
    assign state    = state_r;
    assign instret  = instret_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven self-checking bench for multicycle_ctrl; each row is one clock cycle
// of inputs with the expected state, control word and instret in that cycle.
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [3:0]  state;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .alucontrol(alucontrol),
        .state(state), .instret(instret)
    );

    // Control word: pcen,memwrite,irwrite,regwrite,alusrca,alusrcb,pcsrc,iord,memtoreg,regdst,alucontrol
    localparam logic [14:0] C_FETCH   = 15'b1_0_1_0_0_01_00_0_0_0_010;
    localparam logic [14:0] C_FETCH_R = 15'b0_0_0_0_0_01_00_0_0_0_010;
    localparam logic [14:0] C_DECODE  = 15'b0_0_0_0_0_11_00_0_0_0_010;
    localparam logic [14:0] C_MEMADR  = 15'b0_0_0_0_1_10_00_0_0_0_010;
    localparam logic [14:0] C_MEMRD   = 15'b0_0_0_0_0_00_00_1_0_0_010;
    localparam logic [14:0] C_MEMWB   = 15'b0_0_0_1_0_00_00_0_1_0_010;
    localparam logic [14:0] C_MEMWB_R = 15'b0_0_0_0_0_00_00_0_1_0_010;
    localparam logic [14:0] C_MEMWR   = 15'b0_1_0_0_0_00_00_1_0_0_010;
    localparam logic [14:0] C_EX_SLT  = 15'b0_0_0_0_1_00_00_0_0_0_111;
    localparam logic [14:0] C_EX_DEF  = 15'b0_0_0_0_1_00_00_0_0_0_010;
    localparam logic [14:0] C_ALUWB   = 15'b0_0_0_1_0_00_00_0_0_1_010;
    localparam logic [14:0] C_BR_T    = 15'b1_0_0_0_1_00_01_0_0_0_110;
    localparam logic [14:0] C_BR_N    = 15'b0_0_0_0_1_00_01_0_0_0_110;
    localparam logic [14:0] C_ADDIWB  = 15'b0_0_0_1_0_00_00_0_0_0_010;
    localparam logic [14:0] C_JUMP    = 15'b1_0_0_0_0_00_10_0_0_0_010;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic [3:0] s, input logic [14:0] c, input logic [31:0] i);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.zero = z; v.st = s; v.ctl = c; v.ir = i;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
    task automatic apply(input string tag, input vec_t v);
        logic [14:0] ctl;
        reset = v.rst; op = v.op; funct = v.funct; zero = v.zero;
        #2;
        ctl = {pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, pcsrc,
               iord, memtoreg, regdst, alucontrol};
        check({tag, " state"}, {28'd0, state}, {28'd0, v.st});
        check({tag, " ctl"}, {17'd0, ctl}, {17'd0, v.ctl});
        check({tag, " instret"}, instret, v.ir);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic [31:0] ic;

        // Reset held for three edges (the first outside the table).
        add(1'b1, 6'd0, 6'd0, 1'b0, S_FETCH, C_FETCH_R, 32'd0);
        add(1'b1, 6'd0, 6'd0, 1'b0, S_FETCH, C_FETCH_R, 32'd0);
        // lw: 5 cycles
        add(1'b0, OP_LW, 6'd0, 1'b0, S_FETCH,  C_FETCH,  32'd0);
        add(1'b0, OP_LW, 6'd0, 1'b0, S_DECODE, C_DECODE, 32'd0);
        add(1'b0, OP_LW, 6'd0, 1'b0, S_MEMADR, C_MEMADR, 32'd0);
        add(1'b0, OP_LW, 6'd0, 1'b0, S_MEMRD,  C_MEMRD,  32'd0);
        add(1'b0, OP_LW, 6'd0, 1'b0, S_MEMWB,  C_MEMWB,  32'd0);
        // sw: 4 cycles
        add(1'b0, OP_SW, 6'd0, 1'b0, S_FETCH,  C_FETCH,  32'd1);
        add(1'b0, OP_SW, 6'd0, 1'b0, S_DECODE, C_DECODE, 32'd1);
        add(1'b0, OP_SW, 6'd0, 1'b0, S_MEMADR, C_MEMADR, 32'd1);
        add(1'b0, OP_SW, 6'd0, 1'b0, S_MEMWR,  C_MEMWR,  32'd1);
        // R-type slt
        add(1'b0, OP_RTYPE, FUNCT_SLT, 1'b0, S_FETCH,   C_FETCH,  32'd2);
        add(1'b0, OP_RTYPE, FUNCT_SLT, 1'b0, S_DECODE,  C_DECODE, 32'd2);
        add(1'b0, OP_RTYPE, FUNCT_SLT, 1'b0, S_EXECUTE, C_EX_SLT, 32'd2);
        add(1'b0, OP_RTYPE, FUNCT_SLT, 1'b0, S_ALUWB,   C_ALUWB,  32'd2);
        // R-type with unknown funct decodes to add
        add(1'b0, OP_RTYPE, 6'b111111, 1'b0, S_FETCH,   C_FETCH,  32'd3);
        add(1'b0, OP_RTYPE, 6'b111111, 1'b0, S_DECODE,  C_DECODE, 32'd3);
        add(1'b0, OP_RTYPE, 6'b111111, 1'b0, S_EXECUTE, C_EX_DEF, 32'd3);
        add(1'b0, OP_RTYPE, 6'b111111, 1'b0, S_ALUWB,   C_ALUWB,  32'd3);
        // beq taken and not taken
        add(1'b0, OP_BEQ, 6'd0, 1'b1, S_FETCH,  C_FETCH,  32'd4);
        add(1'b0, OP_BEQ, 6'd0, 1'b1, S_DECODE, C_DECODE, 32'd4);
        add(1'b0, OP_BEQ, 6'd0, 1'b1, S_BEQ,    C_BR_T,   32'd4);
        add(1'b0, OP_BEQ, 6'd0, 1'b0, S_FETCH,  C_FETCH,  32'd5);
        add(1'b0, OP_BEQ, 6'd0, 1'b0, S_DECODE, C_DECODE, 32'd5);
        add(1'b0, OP_BEQ, 6'd0, 1'b0, S_BEQ,    C_BR_N,   32'd5);
        // addi
        add(1'b0, OP_ADDI, 6'd0, 1'b0, S_FETCH,  C_FETCH,  32'd6);
        add(1'b0, OP_ADDI, 6'd0, 1'b0, S_DECODE, C_DECODE, 32'd6);
        add(1'b0, OP_ADDI, 6'd0, 1'b0, S_ADDIEX, C_MEMADR, 32'd6);
        add(1'b0, OP_ADDI, 6'd0, 1'b0, S_ADDIWB, C_ADDIWB, 32'd6);
        // j
        add(1'b0, OP_J, 6'd0, 1'b0, S_FETCH,  C_FETCH,  32'd7);
        add(1'b0, OP_J, 6'd0, 1'b0, S_DECODE, C_DECODE, 32'd7);
        add(1'b0, OP_J, 6'd0, 1'b0, S_JUMP,   C_JUMP,   32'd7);
        // illegal opcode: two cycles, not counted
        add(1'b0, 6'b111111, 6'd0, 1'b0, S_FETCH,  C_FETCH,  32'd8);
        add(1'b0, 6'b111111, 6'd0, 1'b0, S_DECODE, C_DECODE, 32'd8);
        // bne with zero = 0
        add(1'b0, OP_BNE, 6'd0, 1'b0, S_FETCH,  C_FETCH,  32'd8);
        add(1'b0, OP_BNE, 6'd0, 1'b0, S_DECODE, C_DECODE, 32'd8);
`ifdef MC_BNE_EN
        add(1'b0, OP_BNE, 6'd0, 1'b0, S_BNE,    C_BR_T,   32'd8);
        ic = 32'd9;
`else
        ic = 32'd8;
`endif

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("row%0d", i), vecs[i]);
        end

        // Reset during MEMWB of an lw: write-back suppressed, counter cleared, fetch resumes.
        v.funct = 6'd0; v.zero = 1'b0; v.op = OP_LW; v.rst = 1'b0; v.ir = ic;
        v.st = S_FETCH;  v.ctl = C_FETCH;  apply("abort_fetch", v);
        v.st = S_DECODE; v.ctl = C_DECODE; apply("abort_decode", v);
        v.st = S_MEMADR; v.ctl = C_MEMADR; apply("abort_memadr", v);
        v.st = S_MEMRD;  v.ctl = C_MEMRD;  apply("abort_memrd", v);
        v.rst = 1'b1;
        v.st = S_MEMWB;  v.ctl = C_MEMWB_R; apply("abort_memwb", v);
        v.rst = 1'b0; v.ir = 32'd0;
        v.st = S_FETCH;  v.ctl = C_FETCH;  apply("abort_refetch", v);
        v.st = S_DECODE; v.ctl = C_DECODE; apply("abort_redecode", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
